pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/pipe_ctrl_hazard_det.sv | 23 ++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, hold-enable and
// bubble-insert bit positions, and the common masks built from them.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned STALL_W   = 5;
    localparam int unsigned FLUSH_W   = 2;
    localparam int unsigned WAIT_W    = 8;
    localparam int unsigned FCNT_W    = 2;
    localparam int unsigned SCNT_W    = 16;

    // Controller state, visible on state_o
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_ERR     = 2'd3
    } pipe_state_e;

    // Hold-enable bit positions (stall_o)
    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;

    // Bubble-insert bit positions (flush_o)
    localparam int unsigned FLUSH_IFID = 0;
    localparam int unsigned FLUSH_IDEX = 1;

    // Hold-enable masks
    localparam logic [STALL_W-1:0] STALL_NONE    = '0;
    localparam logic [STALL_W-1:0] STALL_LOADUSE =
        STALL_W'((1 << STALL_PC) | (1 << STALL_IFID));
    localparam logic [STALL_W-1:0] STALL_MEMWAIT =
        STALL_W'((1 << STALL_PC) | (1 << STALL_IFID) | (1 << STALL_IDEX) | (1 << STALL_EXMEM));
    localparam logic [STALL_W-1:0] STALL_ALL     =
        STALL_MEMWAIT | STALL_W'(1 << STALL_MEMWB);

    // Bubble-insert masks
    localparam logic [FLUSH_W-1:0] FLUSH_NONE    = '0;
    localparam logic [FLUSH_W-1:0] FLUSH_LOADUSE = FLUSH_W'(1 << FLUSH_IDEX);
    localparam logic [FLUSH_W-1:0] FLUSH_BRANCH  =
        FLUSH_W'((1 << FLUSH_IFID) | (1 << FLUSH_IDEX));

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// register a load in EX is about to write (x0 never hazards).
module hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wreg,
    input  logic                 ex_rmem,
    output logic                 hazard
);

    // Pure combinational match of either used source against the load target
    always_comb begin
        hazard = ex_rmem && ex_wreg && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns memory waits, taken branches and
// load-use hazards into per-stage hold enables and bubble inserts, with a
// sticky memory-timeout error and a count of stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wreg,
    input  logic                 ex_rmem,
    input  logic                 ex_if_inc,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic [STALL_W-1:0]   stall_o,
    output logic [FLUSH_W-1:0]   flush_o,
    output logic [1:0]           state_o,
    output logic                 err_o,
    output logic [SCNT_W-1:0]    stall_cnt_o
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [FCNT_W-1:0] FLUSH_EXTRA = FCNT_W'(FLUSH_CYCLES - 1);

    pipe_state_e         state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [FCNT_W-1:0]   flush_cnt, flush_nxt;
    logic                err;
    logic [SCNT_W-1:0]   stall_cnt;
    logic [STALL_W-1:0]  stall;
    logic [FLUSH_W-1:0]  flush;
    logic                load_use;
    logic                mem_wait;

    hazard_det u_hazard_det (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_wreg    (ex_wreg),
        .ex_rmem    (ex_rmem),
        .hazard     (load_use)
    );

    // A pending access that memory cannot serve this cycle
    always_comb begin
        mem_wait = mem_req && !mem_ready;
    end

    // Next-state and hold/bubble decode; memory wait outranks branch outranks load-use
    always_comb begin
        stall     = STALL_NONE;
        flush     = FLUSH_NONE;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        flush_nxt = flush_cnt;

        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    stall     = STALL_MEMWAIT;
                    state_nxt = ST_MEMWAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (ex_if_inc) begin
                    flush = FLUSH_BRANCH;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        flush_nxt = FLUSH_EXTRA;
                    end
                end else if (load_use) begin
                    stall = STALL_LOADUSE;
                    flush = FLUSH_LOADUSE;
                end
            end

            ST_FLUSH: begin
                if (mem_wait) begin
                    // Remaining flush cycles are dropped; the wait takes over
                    stall     = STALL_MEMWAIT;
                    state_nxt = ST_MEMWAIT;
                    wait_nxt  = WAIT_W'(1);
                    flush_nxt = '0;
                end else begin
                    flush     = FLUSH_BRANCH;
                    flush_nxt = flush_cnt - FCNT_W'(1);
                    if (flush_cnt <= FCNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end

            ST_MEMWAIT: begin
                // EX is frozen here, so branch and load-use inputs are not looked at
                if (mem_ready) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else begin
                    stall = STALL_MEMWAIT;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_nxt = ST_ERR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end

            ST_ERR: begin
                stall = STALL_ALL;
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (!rst_n) begin
            stall = STALL_NONE;
            flush = FLUSH_NONE;
        end
    end

    // State, counters and sticky error register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
            err       <= err || (state_nxt == ST_ERR);
            if (stall != STALL_NONE) begin
                stall_cnt <= stall_cnt + SCNT_W'(1);
            end
        end
    end

    // Output drive
    always_comb begin
        stall_o     = stall;
        flush_o     = flush;
        state_o     = state;
        err_o       = err;
        stall_cnt_o = stall_cnt;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random stimulus,
// expected values from a behavioural model, checked by a separate monitor.
module tb_pipe_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned MT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic        ex_wreg = 1'b0, ex_rmem = 1'b0, ex_if_inc = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b1;
    logic [4:0]  stall_o;
    logic [1:0]  flush_o;
    logic [1:0]  state_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_wreg     (ex_wreg),
        .ex_rmem     (ex_rmem),
        .ex_if_inc   (ex_if_inc),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .state_o     (state_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, wreg, rmem, br, req, rdy, rst_n;
    } stim_t;

    typedef struct {
        logic [4:0]  stall;
        logic [1:0]  flush;
        logic [1:0]  state;
        logic        err;
        logic [15:0] cnt;
        bit          chk_regs;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode 0=run 1=flushing 2=waiting on memory 3=error
    int          m_mode  = 0;
    int          m_fleft = 0;
    int          m_wait  = 0;
    bit          m_err   = 0;
    logic [15:0] m_cnt   = '0;
    bit          m_known = 0;

    task automatic predict(input stim_t s, output exp_t e);
        bit hz, mw;
        hz = s.rmem && s.wreg && (s.rd != 0) &&
             ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        mw = s.req && !s.rdy;
        e.state    = 2'(m_mode);
        e.err      = m_err;
        e.cnt      = m_cnt;
        e.chk_regs = m_known;
        e.stall    = 5'b00000;
        e.flush    = 2'b00;
        if (!s.rst_n) begin
            m_mode = 0; m_fleft = 0; m_wait = 0; m_err = 0; m_cnt = '0; m_known = 1;
        end else begin
            if (m_mode == 0 || m_mode == 1) begin
                if (mw) begin
                    e.stall = 5'b01111; m_mode = 2; m_wait = 1; m_fleft = 0;
                end else if (m_mode == 1) begin
                    e.flush = 2'b11; m_fleft = m_fleft - 1;
                    if (m_fleft == 0) m_mode = 0;
                end else if (s.br) begin
                    e.flush = 2'b11; m_fleft = int'(FC) - 1;
                    m_mode = (m_fleft > 0) ? 1 : 0;
                end else if (hz) begin
                    e.stall = 5'b00011; e.flush = 2'b10;
                end
            end else if (m_mode == 2) begin
                if (s.rdy) begin
                    m_mode = 0;
                end else begin
                    e.stall = 5'b01111;
                    if (m_wait >= int'(MT)) begin
                        m_mode = 3; m_err = 1;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
            end else begin
                e.stall = 5'b11111;
            end
            if (e.stall != 0) m_cnt = m_cnt + 16'd1;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.use1 = 0; s.use2 = 0; s.wreg = 0; s.rmem = 0;
        s.br = 0; s.req = 0; s.rdy = 1; s.rst_n = 1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rs1  = 5'($urandom_range(0, 3));
        s.rs2  = 5'($urandom_range(0, 3));
        s.rd   = 5'($urandom_range(0, 3));
        s.use1 = ($urandom_range(0, 99) < 60);
        s.use2 = ($urandom_range(0, 99) < 60);
        s.wreg = ($urandom_range(0, 99) < 70);
        s.rmem = ($urandom_range(0, 99) < 50);
        s.br   = ($urandom_range(0, 99) < 15);
        s.req  = ($urandom_range(0, 99) < 30);
        s.rdy  = ($urandom_range(0, 99) < 55);
        s.rst_n = !($urandom_range(0, 99) < 2);
        return s;
    endfunction

    function automatic stim_t load_use(input logic [4:0] r);
        stim_t s;
        s = idle();
        s.rmem = 1; s.wreg = 1; s.rd = r; s.rs1 = r; s.use1 = 1;
        return s;
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, advance a clock
    task automatic apply(input stim_t s);
        exp_t e;
        rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
        id_use_rs1 = s.use1; id_use_rs2 = s.use2;
        ex_wreg = s.wreg; ex_rmem = s.rmem; ex_if_inc = s.br;
        mem_req = s.req; mem_ready = s.rdy;
        predict(s, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (stall_o !== e.stall || flush_o !== e.flush) begin
                    errors++;
                    $display("FAIL hold/bubble cyc=%0d got stall=%b flush=%b want stall=%b flush=%b",
                             cyc, stall_o, flush_o, e.stall, e.flush);
                end
                if (e.chk_regs) begin
                    checks++;
                    if (state_o !== e.state || err_o !== e.err || stall_cnt_o !== e.cnt) begin
                        errors++;
                        $display("FAIL regs cyc=%0d got state=%0d err=%b cnt=%h want state=%0d err=%b cnt=%h",
                                 cyc, state_o, err_o, stall_cnt_o, e.state, e.err, e.cnt);
                    end
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        @(posedge clk);
        #1;

        // Reset with garbage on the inputs: outputs must stay quiet
        repeat (2) begin
            s = rnd(); s.rst_n = 0; apply(s);
        end

        // Load-use bubble, then the x0 case that must not hazard
        apply(load_use(5'd5));
        apply(idle());
        apply(load_use(5'd0));
        apply(idle());

        // Taken branch: two flush cycles then back to run
        s = idle(); s.br = 1; apply(s);
        repeat (3) apply(idle());

        // All events at once: memory wait wins, then ready after 3 wait cycles
        s = load_use(5'd7); s.br = 1; s.req = 1; s.rdy = 0; apply(s);
        repeat (3) apply(s);
        s.rdy = 1; s.br = 0; apply(s);
        repeat (2) apply(idle());

        // Memory timeout into the error state, held, then cleared by reset
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (8) apply(s);
        s = idle(); s.rst_n = 0; apply(s);
        repeat (2) apply(idle());

        // Randomised traffic
        for (int i = 0; i < 3000; i++) apply(rnd());

        // Drive the stall counter to 0xFFFF by sitting in the error state, then wrap
        s = idle(); s.rst_n = 0; apply(s);
        s = idle(); s.req = 1; s.rdy = 0;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) apply(s);
        checks++;
        if (m_cnt != 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_setup got cnt=%h want ffff", m_cnt);
        end
        repeat (3) apply(s);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
